// File: rtl/prog_run_ctrl.sv
// prog_run_ctrl: loads CPU data memory, holds/releases/times the CPU, reads back one result byte
module prog_run_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CYC_W = 16,
    parameter int RST_CYC = 2,
    parameter logic [CYC_W-1:0] MAX_CYC = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_reset,
    input  logic              cpu_done,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [CYC_W-1:0]  cycle_ct,
    output logic              timeout
);
    typedef enum logic [2:0] {IDLE, RST, RUN, READ, FIN} state_t;
    localparam int RW = $clog2(RST_CYC + 1);
    state_t state;
    logic [RW-1:0] rst_ct;
    logic rd_ph;
    logic [ADDR_W-1:0] rd_lat;
    logic accept, run_done, run_to;
    assign ld_ready = state == IDLE && !start;
    assign accept = ld_valid && ld_ready;
    assign run_done = cpu_done && cycle_ct != CYC_W'(1);
    assign run_to = cycle_ct == MAX_CYC && !run_done;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cpu_reset <= 1'b1;
            mem_sel <= 1'b1;
            mem_we <= 1'b0;
            res_valid <= 1'b0;
            busy <= 1'b0;
            timeout <= 1'b0;
            cycle_ct <= '0;
            res_data <= '0;
            mem_addr <= '0;
            mem_wdata <= '0;
            rst_ct <= '0;
            rd_ph <= 1'b0;
            rd_lat <= '0;
        end else begin
            mem_we <= accept;
            res_valid <= 1'b0;
            if (accept) begin
                mem_addr <= ld_addr;
                mem_wdata <= ld_data;
            end
            case (state)
                IDLE: if (start) begin
                    state <= RST;
                    rd_lat <= rd_addr;
                    cycle_ct <= '0;
                    timeout <= 1'b0;
                    busy <= 1'b1;
                    rst_ct <= RW'(1);
                end
                RST: if (rst_ct == RW'(RST_CYC)) begin
                    state <= RUN;
                    cpu_reset <= 1'b0;
                    mem_sel <= 1'b0;
                    cycle_ct <= CYC_W'(1);
                end else begin
                    rst_ct <= rst_ct + RW'(1);
                end
                RUN: if (run_done) begin
                    state <= READ;
                    cpu_reset <= 1'b1;
                    mem_sel <= 1'b1;
                    mem_addr <= rd_lat;
                    rd_ph <= 1'b0;
                end else if (run_to) begin
                    state <= FIN;
                    cpu_reset <= 1'b1;
                    mem_sel <= 1'b1;
                    timeout <= 1'b1;
                end else begin
                    cycle_ct <= cycle_ct + CYC_W'(1);
                end
                READ: if (rd_ph) begin
                    res_data <= mem_rdata;
                    res_valid <= 1'b1;
                    state <= FIN;
                end else begin
                    rd_ph <= 1'b1;
                end
                FIN: begin
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_run_ctrl.sv
// tb_prog_run_ctrl: randomized self-checking bench with a memory/CPU environment and result model
module tb_prog_run_ctrl;
    localparam int MAX = 100;
    localparam int RSTC = 2;
    logic clk, reset, ld_valid, ld_ready, start, busy, mem_sel, mem_we;
    logic cpu_reset, cpu_done, res_valid, timeout;
    logic [7:0] ld_addr, ld_data, rd_addr, mem_addr, mem_wdata, mem_rdata, res_data;
    logic [15:0] cycle_ct;
    logic [7:0] env_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] la [8];
    logic [7:0] lv [8];
    int n_pass = 0;
    int n_tot = 0;

    prog_run_ctrl #(.ADDR_W(8), .DATA_W(8), .CYC_W(16), .RST_CYC(RSTC), .MAX_CYC(16'(MAX))) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_data(ld_data), .start(start), .rd_addr(rd_addr), .busy(busy), .mem_sel(mem_sel),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_reset(cpu_reset), .cpu_done(cpu_done), .res_valid(res_valid), .res_data(res_data),
        .cycle_ct(cycle_ct), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_sel && mem_we) env_mem[mem_addr] <= mem_wdata;
        mem_rdata <= env_mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_tot++; if ({cpu_reset, mem_sel, mem_we, res_valid, busy, timeout} !== 6'b110000) $display("FAIL reset_flags got %b exp 110000", {cpu_reset, mem_sel, mem_we, res_valid, busy, timeout}); else n_pass++;
        n_tot++; if (cycle_ct !== 16'd0) $display("FAIL reset_cycle_ct got %0d exp 0", cycle_ct); else n_pass++;
        n_tot++; if ({res_data, mem_addr, mem_wdata} !== 24'd0) $display("FAIL reset_data got %h exp 0", {res_data, mem_addr, mem_wdata}); else n_pass++;
        reset = 1'b1;
        tick();
        n_tot++; if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready got %b exp 1", ld_ready); else n_pass++;
    endtask

    task automatic load_burst(input int n);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_addr = la[i];
            ld_data = lv[i];
            #1;
            n_tot++; if (ld_ready !== 1'b1) $display("FAIL load_ready beat %0d got %b exp 1", i, ld_ready); else n_pass++;
            tick();
            n_tot++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, la[i], lv[i]}) $display("FAIL load_write beat %0d got we=%b a=%h d=%h exp we=1 a=%h d=%h", i, mem_we, mem_addr, mem_wdata, la[i], lv[i]); else n_pass++;
            ref_mem[la[i]] = lv[i];
        end
        ld_valid = 1'b0;
        tick();
        n_tot++; if (mem_we !== 1'b0) $display("FAIL load_idle_we got %b exp 0", mem_we); else n_pass++;
    endtask

    task automatic run_prog(input logic [7:0] rd, input int k, input bit stale, input bit clash, input bit restart);
        int j, rc, nv;
        bit ok, exp_to;
        int exp_ct;
        logic [7:0] got;
        exp_to = !(k >= 2 && k <= MAX);
        exp_ct = exp_to ? MAX : k;
        n_tot++; if (ld_ready !== 1'b1) $display("FAIL run_idle_ready got %b exp 1", ld_ready); else n_pass++;
        start = 1'b1;
        rd_addr = rd;
        cpu_done = stale;
        if (clash) begin
            ld_valid = 1'b1;
            ld_addr = rd;
            ld_data = ~ref_mem[rd];
        end
        #1;
        if (clash) begin
            n_tot++; if (ld_ready !== 1'b0) $display("FAIL clash_ready got %b exp 0", ld_ready); else n_pass++;
        end
        tick();
        start = 1'b0;
        ld_valid = 1'b0;
        rd_addr = 8'($urandom);
        n_tot++; if ({busy, mem_we} !== 2'b10) $display("FAIL start_busy_we got %b exp 10", {busy, mem_we}); else n_pass++;
        rc = 0;
        while (cpu_reset === 1'b1 && rc < 10) begin
            rc++;
            tick();
        end
        n_tot++; if (rc !== RSTC) $display("FAIL rst_hold got %0d exp %0d", rc, RSTC); else n_pass++;
        j = 1;
        ok = 1'b1;
        while (j < 300) begin
            if (cycle_ct !== 16'(j) || mem_sel !== 1'b0 || busy !== 1'b1) ok = 1'b0;
            cpu_done = (j == k) || (stale && j == 1);
            start = restart && j == 5;
            tick();
            if (cpu_reset !== 1'b0) break;
            j++;
        end
        cpu_done = 1'b0;
        start = 1'b0;
        n_tot++; if (ok !== 1'b1) $display("FAIL run_tracking got %b exp 1", ok); else n_pass++;
        n_tot++; if (cycle_ct !== 16'(exp_ct)) $display("FAIL run_cycle_ct got %0d exp %0d", cycle_ct, exp_ct); else n_pass++;
        n_tot++; if (timeout !== exp_to) $display("FAIL run_timeout got %b exp %b", timeout, exp_to); else n_pass++;
        if (!exp_to) begin
            n_tot++; if (mem_addr !== rd) $display("FAIL read_addr got %h exp %h", mem_addr, rd); else n_pass++;
        end
        nv = 0;
        got = 8'h00;
        for (int i = 0; i < 8 && busy === 1'b1; i++) begin
            if (res_valid === 1'b1) begin
                nv++;
                got = res_data;
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            if (res_valid === 1'b1 || busy !== 1'b0) nv += 10;
            tick();
        end
        n_tot++; if (nv !== (exp_to ? 0 : 1)) $display("FAIL res_pulses got %0d exp %0d", nv, exp_to ? 0 : 1); else n_pass++;
        if (!exp_to) begin
            n_tot++; if (got !== ref_mem[rd]) $display("FAIL res_data got %h exp %h", got, ref_mem[rd]); else n_pass++;
        end
        n_tot++; if ({busy, cpu_reset, mem_sel, ld_ready} !== 4'b0111) $display("FAIL post_idle got %b exp 0111", {busy, cpu_reset, mem_sel, ld_ready}); else n_pass++;
        n_tot++; if (cycle_ct !== 16'(exp_ct)) $display("FAIL post_cycle_ct got %0d exp %0d", cycle_ct, exp_ct); else n_pass++;
    endtask

    task automatic test_load();
        la[0] = 8'd1; lv[0] = 8'd5;
        la[1] = 8'd2; lv[1] = 8'd15;
        la[2] = 8'd3; lv[2] = 8'd2;
        la[3] = 8'd5; lv[3] = 8'd150;
        la[4] = 8'd0; lv[4] = 8'hA5;
        la[5] = 8'd255; lv[5] = 8'h5A;
        load_burst(6);
    endtask

    task automatic test_run();
        run_prog(8'd5, 37, 1'b0, 1'b0, 1'b0);
        run_prog(8'd255, MAX, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_prog(8'd2, 0, 1'b0, 1'b0, 1'b0);
        run_prog(8'd1, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start_clash();
        run_prog(8'd3, 20, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_stale_done();
        run_prog(8'd1, 2, 1'b1, 1'b0, 1'b0);
        run_prog(8'd0, 9, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int j, nv;
        start = 1'b1;
        rd_addr = 8'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10 && cpu_reset === 1'b1; i++) tick();
        j = 1;
        while (j < 10 && cpu_reset === 1'b0) begin
            tick();
            j++;
        end
        n_tot++; if (cycle_ct !== 16'd10) $display("FAIL mid_run_ct got %0d exp 10", cycle_ct); else n_pass++;
        reset = 1'b0;
        cpu_done = 1'b1;
        tick();
        reset = 1'b1;
        cpu_done = 1'b0;
        n_tot++; if ({cpu_reset, mem_sel, mem_we, res_valid, busy, timeout} !== 6'b110000) $display("FAIL mid_reset_flags got %b exp 110000", {cpu_reset, mem_sel, mem_we, res_valid, busy, timeout}); else n_pass++;
        n_tot++; if ({cycle_ct, res_data, mem_addr, mem_wdata} !== 40'd0) $display("FAIL mid_reset_data got %h exp 0", {cycle_ct, res_data, mem_addr, mem_wdata}); else n_pass++;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            if (res_valid === 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1) nv++;
            tick();
        end
        n_tot++; if (nv !== 0) $display("FAIL mid_reset_quiet got %0d exp 0", nv); else n_pass++;
    endtask

    task automatic test_random();
        int n, k, pick;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                la[i] = 8'($urandom);
                lv[i] = 8'($urandom);
            end
            load_burst(n);
            pick = $urandom_range(0, 9);
            k = pick == 0 ? 1 : pick == 1 ? 2 : pick == 2 ? MAX : pick == 3 ? 0 : $urandom_range(3, MAX - 1);
            run_prog(la[$urandom_range(0, n - 1)], k, 1'($urandom), 1'($urandom), k > 5);
        end
    endtask

    initial begin
        reset = 1'b0;
        ld_valid = 1'b0;
        ld_addr = 8'h00;
        ld_data = 8'h00;
        start = 1'b0;
        rd_addr = 8'h00;
        cpu_done = 1'b0;
        test_reset();
        test_load();
        test_run();
        test_timeout();
        test_start_clash();
        test_reset_mid_run();
        test_stale_done();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
